// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader slice.
// Contents:
//   BYTE_WIDTH / WORD_WIDTH : widths of the byte stream and of a ROM word
//   state_t                 : 3-bit loader state encoding (S_COUNT_HI .. S_ERROR)
//   accepts_bytes()         : true for the states in which the loader takes stream bytes
package cpu_defines;

  localparam int BYTE_WIDTH = 8;
  localparam int WORD_WIDTH = 32;

  typedef enum logic [2:0] {
    S_COUNT_HI = 3'd0,
    S_COUNT_LO = 3'd1,
    S_DATA     = 3'd2,
    S_CHECK    = 3'd3,
    S_RUN      = 3'd4,
    S_ERROR    = 3'd5
  } state_t;

  function automatic logic accepts_bytes(input state_t s);
    return s inside {S_COUNT_HI, S_COUNT_LO, S_DATA, S_CHECK};
  endfunction

endpackage

// File: rtl/boot_loader_word_assembler.sv
// word_assembler: packs four consecutive bytes (MSB first) into one word.
// Ports:
//   clock, reset  : system clock, asynchronous active-high reset
//   clear         : synchronous flush of the partial word and byte counter
//   load          : byte_in is taken this cycle
//   byte_in       : incoming byte
//   word          : assembled word (registered)
//   word_valid    : one-cycle pulse the cycle after the 4th byte of a word is loaded
//   last_byte     : the next loaded byte completes a word
module word_assembler
  import cpu_defines::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic [BYTE_WIDTH-1:0] byte_in,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_valid,
  output logic                  last_byte
);

  logic [1:0]            byte_count_reg;
  logic [WORD_WIDTH-1:0] word_reg;
  logic                  word_valid_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_count_reg <= 2'd0;
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
    end else if (clear) begin
      byte_count_reg <= 2'd0;
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
    end else begin
      word_valid_reg <= load && (byte_count_reg == 2'd3);
      if (load) begin
        word_reg       <= {word_reg[WORD_WIDTH-BYTE_WIDTH-1:0], byte_in};
        byte_count_reg <= byte_count_reg + 2'd1;
      end
    end
  end

  assign word       = word_reg;
  assign word_valid = word_valid_reg;
  assign last_byte  = (byte_count_reg == 2'd3);

endmodule

// File: rtl/boot_loader.sv
// boot_loader: receives a program image over a byte stream, writes it into the
// instruction ROM and then releases the CPU from reset.
// Image: count (2 bytes BE), count words (4 bytes BE each), checksum byte
// (XOR of every count and data byte).
// Ports:
//   clock, reset        : system clock, asynchronous active-high reset
//   byte_data/valid     : incoming byte stream; byte_ready is the registered accept
//   start               : reload request, honoured only in S_RUN / S_ERROR
//   rom_write_*         : ROM write port (enable is a one-cycle strobe)
//   cpu_reset           : high in every state except S_RUN
//   done / error        : image loaded and verified / sticky fault
module boot_loader
  import cpu_defines::*;
#(
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [BYTE_WIDTH-1:0]    byte_data,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  input  logic                     start,
  output logic                     rom_write_enable,
  output logic [ADDRESS_WIDTH-1:0] rom_write_address,
  output logic [WORD_WIDTH-1:0]    rom_write_data,
  output logic                     cpu_reset,
  output logic                     done,
  output logic                     error
);

  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDRESS_WIDTH;

  state_t                   state_reg, state_next;
  logic [BYTE_WIDTH-1:0]    count_hi_reg;
  logic [15:0]              count_reg;
  logic [BYTE_WIDTH-1:0]    checksum_reg;
  logic [ADDRESS_WIDTH-1:0] address_reg;
  logic                     ready_reg, cpu_reset_reg, done_reg, error_reg;

  logic        accept, restart, load, word_valid, last_byte, last_word;
  logic [15:0] count_value;
  logic [WORD_WIDTH-1:0] word;

  // ready is registered, so acceptance never depends on byte_valid combinationally
  assign accept      = byte_valid && ready_reg;
  assign restart     = start && (state_reg == S_RUN || state_reg == S_ERROR);
  assign load        = accept && (state_reg == S_DATA);
  assign count_value = {count_hi_reg, byte_data};
  // the word index equals the word currently being assembled
  assign last_word   = ({{(16-ADDRESS_WIDTH){1'b0}}, address_reg} == count_reg - 16'd1);

  word_assembler u_word_assembler (
    .clock      (clock),
    .reset      (reset),
    .clear      (restart),
    .load       (load),
    .byte_in    (byte_data),
    .word       (word),
    .word_valid (word_valid),
    .last_byte  (last_byte)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_COUNT_HI: if (accept) state_next = S_COUNT_LO;
      S_COUNT_LO: begin
        if (accept) begin
          if (count_value == 16'd0)                    state_next = S_CHECK;
          else if ({16'd0, count_value} > MAX_WORDS)   state_next = S_ERROR;
          else                                         state_next = S_DATA;
        end
      end
      S_DATA:     if (accept && last_byte && last_word) state_next = S_CHECK;
      S_CHECK: begin
        if (accept) state_next = (byte_data == checksum_reg) ? S_RUN : S_ERROR;
      end
      S_RUN, S_ERROR: if (start) state_next = S_COUNT_HI;
      default:    state_next = S_COUNT_HI;
    endcase
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= S_COUNT_HI;
      ready_reg     <= 1'b0;
      cpu_reset_reg <= 1'b1;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ready_reg     <= accepts_bytes(state_next);
      cpu_reset_reg <= (state_next != S_RUN);
      done_reg      <= (state_next == S_RUN);
      error_reg     <= (state_next == S_ERROR);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_hi_reg <= '0;
      count_reg    <= '0;
      checksum_reg <= '0;
      address_reg  <= '0;
    end else if (restart) begin
      checksum_reg <= '0;
      address_reg  <= '0;
    end else begin
      if (accept && state_reg == S_COUNT_HI) count_hi_reg <= byte_data;
      if (accept && state_reg == S_COUNT_LO) count_reg    <= count_value;
      if (accept && state_reg inside {S_COUNT_HI, S_COUNT_LO, S_DATA})
        checksum_reg <= checksum_reg ^ byte_data;
      // advance after each write, but hold the final address once the image is in
      if (word_valid && state_reg == S_DATA) address_reg <= address_reg + 1'b1;
    end
  end

  assign byte_ready        = ready_reg;
  assign cpu_reset         = cpu_reset_reg;
  assign done              = done_reg;
  assign error             = error_reg;
  assign rom_write_enable  = word_valid;
  assign rom_write_data    = word;
  assign rom_write_address = address_reg;

endmodule
